// File: rtl/sha2_pkg.sv
// Shared SHA-2 (SHA-256 / SHA-224) definitions: word type, round constants,
// initial hash values, the bitwise round/schedule functions and the FSM state type.
package sha2_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_t;

    localparam int ROUNDS = 64;

    localparam word_t [0:63] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t [0:7] H256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t [0:7] H224_IV = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t sum0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t sum1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha2_round.sv
// One combinational SHA-2 compression round. hv[0..7] = a..h.
module sha2_round
    import sha2_pkg::*;
(
    input  word_t [0:7] hv_i,
    input  word_t       k_i,
    input  word_t       w_i,
    output word_t [0:7] hv_o
);

    word_t t1;
    word_t t2;

    // Two temporaries of the round, then the a..h rotation.
    always_comb begin
        t1   = hv_i[7] + sum1(hv_i[4]) + ch(hv_i[4], hv_i[5], hv_i[6]) + k_i + w_i;
        t2   = sum0(hv_i[0]) + maj(hv_i[0], hv_i[1], hv_i[2]);
        hv_o = {t1 + t2, hv_i[0], hv_i[1], hv_i[2], hv_i[3] + t1, hv_i[4], hv_i[5], hv_i[6]};
    end

endmodule

// File: rtl/sha2_compress_core.sv
// Iterative SHA-256 / SHA-224 compression core with block chaining.
// Optional feature macro SHA2_ABORT_EN adds an abort_i input that drops
// any message in flight and returns to IDLE.
//
// state | meaning
// IDLE  | waiting for a block; chaining state kept if mid-message
// ROUND | ROUNDS_PER_CYCLE rounds per clock over the schedule window
// FINAL | fold a..h into the chain; publish digest on last block
// OUT   | digest held until consumer handshake
module sha2_compress_core
    import sha2_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid_i,
    output logic         blk_ready_o,
    input  logic [511:0] blk_data_i,
    input  logic         blk_first_i,
    input  logic         blk_last_i,
    input  logic         mode_224_i,
`ifdef SHA2_ABORT_EN
    input  logic         abort_i,
`endif
    output logic         digest_valid_o,
    input  logic         digest_ready_i,
    output logic [255:0] digest_o,
    output logic         busy_o
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rpc
        $error("sha2_compress_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    localparam logic [5:0] T_STEP = 6'(ROUNDS_PER_CYCLE);
    localparam logic [5:0] T_LAST = 6'(ROUNDS - ROUNDS_PER_CYCLE);

    state_t state, next_state;
    logic   abort;
    logic   accept;

    word_t [0:7]  chain;
    word_t [0:7]  chain_sum;
    word_t [0:7]  work;
    word_t [0:7]  rnd_out;
    word_t [0:15] window;
    word_t [0:15+ROUNDS_PER_CYCLE] ext;
    logic  [5:0]  t;
    logic         chain_valid;
    logic         last_q;
    logic         mode_q;

`ifdef SHA2_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    assign accept = blk_valid_i & blk_ready_o;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and handshake outputs; abort overrides everything.
    always_comb begin
        next_state     = state;
        blk_ready_o    = 1'b0;
        digest_valid_o = 1'b0;
        busy_o         = 1'b1;
        case (state)
            IDLE: begin
                blk_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (blk_valid_i) next_state = ROUND;
            end
            ROUND: if (t == T_LAST) next_state = FINAL;
            FINAL: next_state = last_q ? OUT : IDLE;
            OUT: begin
                digest_valid_o = 1'b1;
                if (digest_ready_i) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (abort) begin
            next_state  = IDLE;
            blk_ready_o = 1'b0;
        end
    end

    // Extend the window by ROUNDS_PER_CYCLE new schedule words; later words
    // may depend on earlier new ones, so they are computed in order.
    always_comb begin
        ext       = '0;
        ext[0:15] = window;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++)
            ext[16+j] = sigma1(ext[14+j]) + ext[9+j] + sigma0(ext[1+j]) + ext[j];
    end

    for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_rnd
        word_t [0:7] hv_in;
        word_t [0:7] hv_out;
        if (i == 0) begin : g_head
            assign hv_in = work;
        end else begin : g_tail
            assign hv_in = g_rnd[i-1].hv_out;
        end
        sha2_round u_round (
            .hv_i (hv_in),
            .k_i  (K[t + 6'(i)]),
            .w_i  (ext[i]),
            .hv_o (hv_out)
        );
    end

    assign rnd_out = g_rnd[ROUNDS_PER_CYCLE-1].hv_out;

    // Chain update folded in at FINAL.
    always_comb begin
        chain_sum = '0;
        for (int i = 0; i < 8; i++) chain_sum[i] = chain[i] + work[i];
    end

    // Datapath: block load, round iteration, chaining and digest publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain       <= '0;
            work        <= '0;
            window      <= '0;
            t           <= '0;
            chain_valid <= 1'b0;
            last_q      <= 1'b0;
            mode_q      <= 1'b0;
            digest_o    <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    window <= blk_data_i;
                    t      <= '0;
                    last_q <= blk_last_i;
                    if (blk_first_i || !chain_valid) begin
                        chain  <= mode_224_i ? H224_IV : H256_IV;
                        work   <= mode_224_i ? H224_IV : H256_IV;
                        mode_q <= mode_224_i;
                    end else begin
                        work <= chain;
                    end
                end
                ROUND: begin
                    work   <= rnd_out;
                    window <= ext[ROUNDS_PER_CYCLE +: 16];
                    t      <= t + T_STEP;
                end
                FINAL: begin
                    chain       <= chain_sum;
                    chain_valid <= 1'b1;
                    if (last_q)
                        digest_o <= {chain_sum[0:6], mode_q ? 32'h0 : chain_sum[7]};
                end
                OUT: if (digest_ready_i) chain_valid <= 1'b0;
                default: ;
            endcase
            if (abort) chain_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sha2_compress_core.sv
// Scoreboard bench for sha2_compress_core: known-answer vectors, latency,
// digest hold, multi-block chaining, restart and reset (and abort when
// SHA2_ABORT_EN is defined).
module tb_sha2_compress_core;

    localparam int RPC = 1;
    localparam int LAT = 64 / RPC + 1;

    localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] M2_B1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] M2_B2 = {480'h0, 32'h000001c0};

    localparam logic [255:0] D_ABC256 =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_ABC224 =
        {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
    localparam logic [255:0] D_M2 =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         blk_valid = 1'b0;
    logic         blk_first = 1'b0;
    logic         blk_last = 1'b0;
    logic         mode_224 = 1'b0;
    logic         digest_ready = 1'b0;
    logic [511:0] blk_data = '0;
    logic         blk_ready;
    logic         digest_valid;
    logic         busy;
    logic [255:0] digest;
`ifdef SHA2_ABORT_EN
    logic         abort = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [255:0] sb_q[$];

    always #5 clk = ~clk;

    sha2_compress_core #(.ROUNDS_PER_CYCLE(RPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .blk_valid_i    (blk_valid),
        .blk_ready_o    (blk_ready),
        .blk_data_i     (blk_data),
        .blk_first_i    (blk_first),
        .blk_last_i     (blk_last),
        .mode_224_i     (mode_224),
`ifdef SHA2_ABORT_EN
        .abort_i        (abort),
`endif
        .digest_valid_o (digest_valid),
        .digest_ready_i (digest_ready),
        .digest_o       (digest),
        .busy_o         (busy)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 256'(blk_ready), 256'd1);
        chk({tag, "_dvalid"}, 256'(digest_valid), 256'd0);
        chk({tag, "_busy"}, 256'(busy), 256'd0);
    endtask

    // Offer a block and return #1 after the accepting edge.
    task automatic send(input logic [511:0] d, input logic first, input logic last,
                        input logic mode, input logic [255:0] exp_d);
        int n = 0;
        @(negedge clk);
        blk_data  = d;
        blk_first = first;
        blk_last  = last;
        mode_224  = mode;
        blk_valid = 1'b1;
        while (!blk_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 256'(blk_ready), 256'd1);
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        blk_data  = {16{32'hdeadbeef}};
        blk_first = 1'b0;
        blk_last  = 1'b0;
        if (last) sb_q.push_back(exp_d);
    endtask

    // After a non-last block: ready low, then back after LAT edges.
    task automatic wait_ready();
        int k = 0;
        chk("ready_low_mid", 256'(blk_ready), 256'd0);
        while (!blk_ready && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("ready_latency", 256'(k), 256'(LAT));
    endtask

    // After a last block: latency, digest vs scoreboard, hold, handshake.
    task automatic wait_digest(input int hold);
        int k = 0;
        logic [255:0] exp_d;
        while (!digest_valid && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("digest_latency", 256'(k), 256'(LAT));
        chk("sb_pending", 256'(sb_q.size()), 256'd1);
        exp_d = '0;
        if (sb_q.size() != 0) exp_d = sb_q.pop_front();
        chk("digest", digest, exp_d);
        if (hold > 0) begin
            blk_valid = 1'b1;
            blk_first = 1'b1;
            blk_last  = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_digest", digest, exp_d);
            chk("hold_ready", 256'(blk_ready), 256'd0);
            chk("hold_dvalid", 256'(digest_valid), 256'd1);
        end
        blk_valid    = 1'b0;
        blk_first    = 1'b0;
        blk_last     = 1'b0;
        digest_ready = 1'b1;
        @(posedge clk);
        #1;
        digest_ready = 1'b0;
        chk_idle("post_hs");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_idle("reset");
        chk("reset_digest", digest, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(ABC, 1'b1, 1'b1, 1'b0, D_ABC256);
        wait_digest(10);

        send(ABC, 1'b1, 1'b1, 1'b1, D_ABC224);
        wait_digest(0);

        // chain_valid cleared after the digest: first=0 still loads the IV
        send(ABC, 1'b0, 1'b1, 1'b0, D_ABC256);
        wait_digest(0);

        // two-block message; mode on the second block must be ignored
        send(M2_B1, 1'b1, 1'b0, 1'b0, '0);
        wait_ready();
        send(M2_B2, 1'b0, 1'b1, 1'b1, D_M2);
        wait_digest(0);

        // restart mid-message discards the old chain
        send(M2_B1, 1'b1, 1'b0, 1'b0, '0);
        wait_ready();
        send(ABC, 1'b1, 1'b1, 1'b1, D_ABC224);
        wait_digest(0);

        // reset in the middle of the second block's rounds
        send(M2_B1, 1'b1, 1'b0, 1'b0, '0);
        wait_ready();
        send(M2_B2, 1'b0, 1'b1, 1'b0, D_M2);
        repeat (64 / RPC / 2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_idle("midrst");
        chk("midrst_digest", digest, 256'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(ABC, 1'b1, 1'b1, 1'b0, D_ABC256);
        wait_digest(0);

`ifdef SHA2_ABORT_EN
        // abort mid-message; a block offered alongside must not be taken
        send(M2_B1, 1'b1, 1'b0, 1'b0, '0);
        wait_ready();
        send(M2_B2, 1'b0, 1'b1, 1'b0, D_M2);
        repeat (64 / RPC / 2) @(posedge clk);
        @(negedge clk);
        abort     = 1'b1;
        blk_valid = 1'b1;
        blk_data  = ABC;
        blk_first = 1'b1;
        blk_last  = 1'b1;
        @(posedge clk);
        #1;
        abort     = 1'b0;
        blk_valid = 1'b0;
        blk_first = 1'b0;
        blk_last  = 1'b0;
        chk_idle("abort");
        sb_q.delete();
        send(ABC, 1'b0, 1'b1, 1'b0, D_ABC256);
        wait_digest(0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sha2_compress_core.md
Name: sha2_compress_core

Overview:
- Iterative SHA-2 (SHA-256 / SHA-224) compression engine, built on the shared SHA-2 package.
- Accepts 512-bit pre-padded message blocks over a valid/ready handshake and chains intermediate hash state across multi-block messages.
- Emits the final digest over a second valid/ready handshake.
- Throughput is set by a compile-time rounds-per-cycle unroll factor; hash mode is selected per message at run time.

Parameters:
- ROUNDS_PER_CYCLE, 1, compression rounds per clock; legal values 1, 2, 4, 8; elaboration error otherwise.
- ROUNDS, 64, rounds per block; fixed by the standard, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- blk_valid_i  input  1  block offered.
- blk_ready_o  output  1  core can accept a block.
- blk_data_i  input  512  message block; W0 = bits [511:480], big-endian words.
- blk_first_i  input  1  block starts a new message; load the IV.
- blk_last_i  input  1  block ends the message; publish the digest.
- mode_224_i  input  1  1 = SHA-224, 0 = SHA-256; sampled only on first blocks.
- digest_valid_o  output  1  digest available.
- digest_ready_i  input  1  consumer takes the digest.
- digest_o  output  256  H0..H7, H0 at [255:224]; in SHA-224 mode [31:0] is forced to 0.
- busy_o  output  1  state is not IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, blk_ready_o=1, digest_valid_o=0, digest_o=0, busy_o=0.
- Reset clears the chaining registers and the chain_valid flag to 0.
- FSM states: IDLE -> ROUND -> FINAL -> (OUT if last, else IDLE); OUT -> IDLE on digest handshake.
- IDLE: blk_ready_o=1. On blk_valid_i & blk_ready_o:
  - latch the block into a 16-word schedule window;
  - if blk_first_i=1 or chain_valid=0, load the IV selected by mode_224_i into chain and a..h, and latch the mode;
  - otherwise load a..h from chain; mode_224_i is ignored.
- ROUND: lasts ROUNDS/ROUNDS_PER_CYCLE cycles, counted by round counter t (0..63, step ROUNDS_PER_CYCLE).
  - Each cycle applies ROUNDS_PER_CYCLE chained rounds using K[t+i] and W[t+i].
  - Schedule: W[t] = blk word for t<16; else sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], all mod 2^32.
  - The window shifts by ROUNDS_PER_CYCLE words per cycle.
- FINAL (1 cycle):
  - chain[i] += a..h[i] mod 2^32; chain_valid=1;
  - if last: digest_o <= new chain and go to OUT; else go to IDLE.
- OUT: digest_valid_o=1, blk_ready_o=0, digest_o held stable until digest_ready_i=1; then IDLE with chain_valid=0.
- Latency, counted from the accepting edge: digest_valid_o rises after ROUNDS/ROUNDS_PER_CYCLE+1 cycles.
  - A non-last block returns blk_ready_o=1 after the same count.
- blk_first_i=1 on a block received mid-message: the message restarts and the old chain is discarded.
- blk_valid_i is ignored outside IDLE; blk_data_i is don't-care when not accepted.
- digest_ready_i is ignored unless digest_valid_o=1.
- Reset asserted in any state: immediate return to the reset values above; any partial message is lost.
- Ch(x,y,z) = (x&y)^(~x&z); Maj(x,y,z) = (x&y)^(x&z)^(y&z); all additions wrap at 32 bits.

Optional Feature:
- Macro: SHA2_ABORT_EN.
- Defined: adds port abort_i (input, 1). abort_i=1 in any state:
  - next state is IDLE and chain_valid=0;
  - digest_valid_o drops on the next edge;
  - a block offered in the same cycle as abort is not accepted.
- Undefined: no abort_i port; a message can only be terminated by completing it or by reset.

Decomposition:
- sha2_pkg holds:
  - word_t (32-bit);
  - K[0:63];
  - H256_IV;
  - H224_IV = c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4;
  - functions sigma0, sigma1, sum0, sum1, Ch, Maj;
  - state_t enum {IDLE, ROUND, FINAL, OUT}.
- One sub-module, sha2_round: a combinational single round (a..h, K, W in; a..h out), instantiated ROUNDS_PER_CYCLE times in series.
- The schedule logic stays in the core.

Test Plan:
- "abc" padded, one block, first=last=1, mode=0 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; valid 65 cycles after accept (ROUNDS_PER_CYCLE=1).
- Same block, mode=1 -> digest 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, low word 0.
- "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" as two blocks, mode=0 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - blk_ready_o must deassert between the blocks.
- digest_ready_i held low 10 cycles -> digest_o stable, blk_ready_o=0 throughout; IDLE one cycle after the handshake.
- Sweep ROUNDS_PER_CYCLE=1/2/4/8 on the "abc" vector -> same digest; latency 65/33/17/9 cycles.
- rst_n pulsed low mid-ROUND of the second block -> outputs at reset values; a fresh "abc" vector then hashes correctly.
  - With SHA2_ABORT_EN, abort_i gives the same result without reset.
